register_read_seq: RTL and testbench
====================================

# register_read_seq

Two-operand read sequencer for the 4×8-bit general register stack (R0–R3). On a start pulse it fetches a source and a destination register, one per cycle, into latched operand registers `opa`/`opb` for the ALU, then signals completion. It sits between the instruction decoder and the ALU, on the read side of the register stack whose write port is driven by `LDPI`, `{I9,I8}` and `write_data`. Same-cycle writes to the register being read are forwarded.

## Interface
- No parameters. Data width is fixed at 8 bits and the register count at 4.
- `clk` in 1: system clock, rising-edge active.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a fetch. Sampled only in IDLE.
- `one_op` in 1: single-operand instruction. Fetch `opa` only. Sampled with `start`.
- `rs_sel` in 2: source register index, feeds `opa`. Sampled with `start`.
- `rd_sel` in 2: destination register index, feeds `opb`. Sampled with `start`.
- `in_R0`..`in_R3` in 8 each: current register-stack contents.
- `wr_en` in 1: register-stack write strobe (LDPI) for the current cycle.
- `wr_addr` in 2: write index `{I9,I8}`.
- `wr_data` in 8: write data.
- `opa` out 8: latched source operand.
- `opb` out 8: latched destination operand.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse when both operands are valid.

## Operation
- States: IDLE, RD_A, RD_B, FIN. Encoding is free. Reset enters IDLE.
- **IDLE**
  - If `start`=1, latch `rs_sel`, `rd_sel` and `one_op` into internal registers and go to RD_A.
  - Otherwise stay in IDLE.
- **RD_A**
  - Load `opa` with the register selected by latched `rs_sel`.
  - Go to FIN if latched `one_op`=1, otherwise go to RD_B.
- **RD_B**
  - Load `opb` with the register selected by latched `rd_sel`. Go to FIN.
- **FIN**
  - `done`=1. If latched `one_op`=1, `opb` is loaded with 0 at this edge.
  - Always return to IDLE. `start` in FIN is ignored.
- **Forwarding:** in any read cycle where `wr_en`=1 and `wr_addr` equals the index being read, the operand loads `wr_data`, not `in_Rx`. A write to a register not being read has no effect on the operand.
- Select inputs are captured only at the IDLE start edge. Changing `rs_sel`/`rd_sel` mid-sequence has no effect.
- `opa`/`opb` hold their values between sequences and change only in RD_A, RD_B, or FIN (one_op case).
- `start` is ignored while `busy`=1. It is not queued.

## Timing
- Edge 0 samples `start` in IDLE.
- Two-operand sequence:
  - Edge 1: `opa` valid after this edge.
  - Edge 2: `opb` valid after this edge.
  - `done` high between edges 2 and 3.
- Single-operand sequence: `opa` valid after edge 1. `done` high between edges 1 and 2, and `opb`=0 after edge 2.
- Minimum start-to-start spacing: 4 cycles (two-operand) and 3 cycles (single-operand).
- `busy` rises after edge 0 and falls after the edge that leaves FIN.
- `done` and `busy` are registered outputs. The `in_Rx` to `opa`/`opb` path is register-to-register.
- Reset values: `opa`=0, `opb`=0, `busy`=0, `done`=0, all internal select latches = 0, state = IDLE.
- Reset asserted mid-sequence: all outputs clear asynchronously and no `done` is produced. After reset release the block waits in IDLE for a new `start`.
- `start` and `rst_n` release in the same cycle: `start` is honoured only if `rst_n` is already high at that edge.

## Test plan
- **Reset:** hold `rst_n`=0 with `start`=1 and random inputs. Required: `opa`=`opb`=0, `busy`=`done`=0. Deassert and check the block remains in IDLE until a fresh `start`.
- **Two-operand read:** R0..R3 = 0x11/0x22/0x33/0x44; `start` with `rs_sel`=2, `rd_sel`=1. Required: `opa`=0x33 after edge 1, `opb`=0x22 after edge 2, `done` for exactly one cycle, then `busy`=0.
- **Single-operand read:** `one_op`=1, `rs_sel`=3. Required: `opa`=0x44, `opb`=0x00, `done` in the 2nd cycle after start.
- **Forwarding:** in the RD_B cycle drive `wr_en`=1, `wr_addr`=1, `wr_data`=0x10, with `rd_sel`=1. Required: `opb`=0x10, not 0x22. Repeat with `wr_addr`=0: `opb`=0x22.
- **Ignored start:** pulse `start` with new selects during RD_A and FIN. Required: no extra `done`, and operands reflect only the first request.
- **Mid-operation reset:** assert `rst_n`=0 in RD_B. Required: immediate clear of all outputs, no `done` after release; a following `start` with `rs_sel`=0, `rd_sel`=3 yields 0x11/0x44.

Source files
------------

// File: rtl/register_read_seq.sv
// Two-operand read sequencer for the 4x8 register stack: fetches source then
// destination into opa/opb, with same-cycle write forwarding from the write port.
module register_read_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       one_op,
    input  logic [1:0] rs_sel,
    input  logic [1:0] rd_sel,
    input  logic [7:0] in_R0,
    input  logic [7:0] in_R1,
    input  logic [7:0] in_R2,
    input  logic [7:0] in_R3,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] opa,
    output logic [7:0] opb,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, FIN} state_t;

    state_t     state, state_nxt;
    logic [1:0] rs_q, rd_q;
    logic       one_q;
    logic [1:0] rd_idx;
    logic [7:0] rd_val;

    // One shared read port: RD_B reads the destination, every other state the source.
    always_comb begin
        rd_idx = (state == RD_B) ? rd_q : rs_q;
        case (rd_idx)
            2'd0:    rd_val = in_R0;
            2'd1:    rd_val = in_R1;
            2'd2:    rd_val = in_R2;
            default: rd_val = in_R3;
        endcase
        if (wr_en && (wr_addr == rd_idx))
            rd_val = wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RD_A;
            RD_A:    state_nxt = one_q ? FIN : RD_B;
            RD_B:    state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rs_q  <= '0;
            rd_q  <= '0;
            one_q <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == FIN);
            if (state == IDLE && start) begin
                rs_q  <= rs_sel;
                rd_q  <= rd_sel;
                one_q <= one_op;
            end
            case (state)
                RD_A:    opa <= rd_val;
                RD_B:    opb <= rd_val;
                FIN:     if (one_q) opb <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_read_seq.sv
// Directed + randomized bench for register_read_seq against a per-transaction
// model: operand = forwarded write data if the write hits the read index, else the stack.
module tb_register_read_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, one_op, wr_en;
    logic [1:0] rs_sel, rd_sel, wr_addr;
    logic [7:0] wr_data;
    logic [7:0] in_R0, in_R1, in_R2, in_R3;
    logic [7:0] opa, opb;
    logic       busy, done;

    logic [7:0] rf [4];
    logic [7:0] mopa, mopb;
    int         checks = 0;
    int         failures = 0;

    assign in_R0 = rf[0];
    assign in_R1 = rf[1];
    assign in_R2 = rf[2];
    assign in_R3 = rf[3];

    always #5 clk = ~clk;

    register_read_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .one_op(one_op),
        .rs_sel(rs_sel), .rd_sel(rd_sel),
        .in_R0(in_R0), .in_R1(in_R1), .in_R2(in_R2), .in_R3(in_R3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .opa(opa), .opb(opb), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fetch(input logic [1:0] idx, input bit we,
                                         input logic [1:0] wa, input logic [7:0] wd);
        return (we && wa == idx) ? wd : rf[idx];
    endfunction

    // Advance one clock; the register stack commits the write after the DUT sampled it.
    task automatic tick();
        @(negedge clk);
        if (wr_en) rf[wr_addr] = wr_data;
        wr_en = 1'b0;
    endtask

    task automatic scramble(input bit noise);
        start  = noise;
        one_op = 1'($urandom_range(1));
        rs_sel = 2'($urandom_range(3));
        rd_sel = 2'($urandom_range(3));
    endtask

    task automatic run_seq(input bit one, input logic [1:0] rs, input logic [1:0] rd,
                           input bit wea, input logic [1:0] aa, input logic [7:0] da,
                           input bit web, input logic [1:0] ab, input logic [7:0] db,
                           input bit noise);
        start = 1'b1; one_op = one; rs_sel = rs; rd_sel = rd;
        tick();
        chk("busy_after_start", {7'd0, busy}, 8'd1);
        chk("done_after_start", {7'd0, done}, 8'd0);
        scramble(noise);
        wr_en = wea; wr_addr = aa; wr_data = da;
        mopa = fetch(rs, wea, aa, da);
        tick();
        chk("opa_rd_a", opa, mopa);
        chk("opb_hold_rd_a", opb, mopb);
        chk("done_rd_a", {7'd0, done}, {7'd0, one});
        chk("busy_rd_a", {7'd0, busy}, 8'd1);
        if (!one) begin
            scramble(noise);
            wr_en = web; wr_addr = ab; wr_data = db;
            mopb = fetch(rd, web, ab, db);
            tick();
            chk("opb_rd_b", opb, mopb);
            chk("opa_hold_rd_b", opa, mopa);
            chk("done_rd_b", {7'd0, done}, 8'd1);
            chk("busy_rd_b", {7'd0, busy}, 8'd1);
        end else begin
            mopb = 8'h00;
        end
        scramble(noise);
        tick();
        chk("opa_end", opa, mopa);
        chk("opb_end", opb, mopb);
        chk("done_end", {7'd0, done}, 8'd0);
        chk("busy_end", {7'd0, busy}, 8'd0);
        start = 1'b0;
        tick();
        chk("done_idle", {7'd0, done}, 8'd0);
        chk("busy_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; wr_en = 1'b1;
        one_op = 1'b0; rs_sel = 2'd2; rd_sel = 2'd1; wr_addr = 2'd1; wr_data = 8'hA5;
        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
        mopa = 8'h00; mopb = 8'h00;

        // Reset held with start asserted
        repeat (3) begin
            @(negedge clk);
            scramble(1'b1);
            wr_en = 1'b1; wr_data = 8'($urandom);
        end
        chk("rst_opa", opa, 8'h00);
        chk("rst_opb", opb, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        wr_en = 1'b0; start = 1'b0; rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_done", {7'd0, done}, 8'd0);
        chk("idle_opa", opa, 8'h00);

        // Two-operand, single-operand, forwarding hit and miss
        run_seq(1'b0, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        run_seq(1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        run_seq(1'b0, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h10, 1'b0);
        rf[1] = 8'h22;
        run_seq(1'b0, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h10, 1'b0);
        rf[0] = 8'h11;

        // Start pulses with new selects while busy are ignored
        run_seq(1'b0, 2'd1, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);
        run_seq(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1);

        // Reset in RD_B
        start = 1'b1; one_op = 1'b0; rs_sel = 2'd3; rd_sel = 2'd2;
        tick();
        start = 1'b0;
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_opa", opa, 8'h00);
        chk("midrst_opb", opb, 8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mopa = 8'h00; mopb = 8'h00;
        repeat (3) begin
            tick();
            chk("postrst_done", {7'd0, done}, 8'd0);
            chk("postrst_busy", {7'd0, busy}, 8'd0);
        end
        run_seq(1'b0, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("postrst_opa", opa, 8'h11);
        chk("postrst_opb", opb, 8'h44);

        // Randomized sequences
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0)
                for (int r = 0; r < 4; r++) rf[r] = 8'($urandom);
            run_seq(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                    1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom),
                    1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom),
                    1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
